// File: rtl/crc8_frame_tx.sv
// Transmit frame sequencer for a bit-serial CRC-8 byte engine.
// Each payload byte is handed to the engine, forwarded downstream once the
// engine reports done, and the frame is closed with the engine's CRC byte.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for first byte to show up
// CLR    | one-cycle engine clear, frame length reset
// ACCEPT | in_ready high, take next payload byte
// START  | one-cycle engine start pulse for the held byte
// WAIT   | waiting for engine done, timeout counter running
// SEND   | payload byte offered downstream
// CRC    | CRC byte offered downstream with out_last
// ABORT  | engine fault, drain input through in_last
module crc8_frame_tx #(
  parameter int unsigned MAX_LEN      = 255,
  parameter int unsigned DONE_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic [7:0] crc_byte,
  output logic       crc_enable,
  output logic       crc_clr,
  input  logic [7:0] crc_value,
  input  logic       crc_done,
  output logic       err_len,
  output logic       err_timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ACCEPT, S_START, S_WAIT, S_SEND, S_CRC, S_ABORT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);
  localparam logic [8:0] LEN_MAX  = 9'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic [7:0] crc_byte_q, crc_byte_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_last_q, crc_enable_q, crc_clr_q, busy_q;
  logic       err_len_q, err_len_d;
  logic       err_tmo_q, err_tmo_d;
  logic       forced_last;

  // ABORT also asserts ready so the rest of a faulted frame is swallowed
  assign in_ready    = (state_q == S_ACCEPT) || (state_q == S_ABORT);
  assign forced_last = ({1'b0, len_q} + 9'd1) == LEN_MAX;

  // Next-state and datapath decode
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    data_d     = data_q;
    last_d     = last_q;
    crc_byte_d = crc_byte_q;
    out_data_d = out_data_q;
    err_len_d  = 1'b0;
    err_tmo_d  = 1'b0;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_CLR;
      S_CLR: begin
        len_d   = '0;
        state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (in_valid) begin
          data_d     = in_data;
          crc_byte_d = in_data;
          last_d     = in_last | forced_last;
          err_len_d  = forced_last & ~in_last;
          len_d      = len_q + 8'd1;
          state_d    = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (crc_done) begin
          out_data_d = data_q;
          state_d    = S_SEND;
        end else if (tmo_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          // if the faulted byte already closed the frame there is nothing to drain
          state_d   = last_q ? S_IDLE : S_ABORT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (last_q) begin
            out_data_d = crc_value;
            state_d    = S_CRC;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      S_CRC:    if (out_ready) state_d = S_IDLE;
      S_ABORT:  if (in_valid && in_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; strobes follow the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      tmo_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      crc_byte_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      crc_enable_q <= 1'b0;
      crc_clr_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      tmo_q        <= tmo_d;
      data_q       <= data_d;
      last_q       <= last_d;
      crc_byte_q   <= crc_byte_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= (state_d == S_SEND) || (state_d == S_CRC);
      out_last_q   <= (state_d == S_CRC);
      crc_enable_q <= (state_d == S_START);
      crc_clr_q    <= (state_d == S_CLR);
      err_len_q    <= err_len_d;
      err_tmo_q    <= err_tmo_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign crc_byte    = crc_byte_q;
  assign crc_enable  = crc_enable_q;
  assign crc_clr     = crc_clr_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_tmo_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Bench for crc8_frame_tx with a behavioural CRC-8 engine (poly 0x07) and an
// output scoreboard. MAX_LEN is reduced to 4 so the forced-last path is reachable.
module tb_crc8_frame_tx;

  localparam int MAX_LEN = 4;
  localparam int TMO     = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] crc_byte;
  logic       crc_enable, crc_clr;
  logic [7:0] crc_value;
  logic       crc_done;
  logic       err_len, err_timeout, busy;

  int tests = 0;
  int fails = 0;

  crc8_frame_tx #(.MAX_LEN(MAX_LEN), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .crc_byte(crc_byte), .crc_enable(crc_enable), .crc_clr(crc_clr),
    .crc_value(crc_value), .crc_done(crc_done),
    .err_len(err_len), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  // behavioural engine: 9 cycles per byte, optional stuck-done fault
  logic [7:0] eng_crc, eng_byte;
  int         eng_cnt;
  logic       eng_no_done = 1'b0;
  assign crc_value = eng_crc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt  <= 0;
      crc_done <= 1'b0;
      eng_crc  <= 8'h00;
      eng_byte <= 8'h00;
    end else begin
      crc_done <= 1'b0;
      if (crc_clr) eng_crc <= 8'h00;
      if (crc_enable) begin
        eng_byte <= crc_byte;
        eng_cnt  <= eng_no_done ? 0 : 9;
      end else if (eng_cnt > 0) begin
        tests++;
        if (crc_byte !== eng_byte) begin
          fails++;
          $display("FAIL crc_byte_stable: got %02h want %02h", crc_byte, eng_byte);
        end
        if (eng_cnt == 1) begin
          crc_done <= 1'b1;
          eng_crc  <= crc8_upd(eng_crc, eng_byte);
        end
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // scoreboard of {last, data} plus pulse counters
  logic [8:0] exp_q[$];
  logic [7:0] fr_crc = 8'h00;
  int         fr_len = 0;
  int         cyc = 0, en_cyc = 0, tmo_cyc = 0;
  int         clr_cnt = 0, en_cnt = 0, errlen_cnt = 0, errtmo_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (crc_clr) clr_cnt++;
      if (crc_enable) begin en_cnt++; en_cyc = cyc; end
      if (err_len) errlen_cnt++;
      if (err_timeout) begin errtmo_cnt++; tmo_cyc = cyc; end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got last=%0b data=%02h want nothing", out_last, out_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            fails++;
            $display("FAIL sb_byte: got last=%0b data=%02h want last=%0b data=%02h",
                     out_last, out_data, e[8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input bit exp_out);
    int n = 0;
    @(negedge clk);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        tests++; fails++;
        $display("FAIL in_handshake_timeout: got in_ready=0 want 1 within 300 cycles");
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (exp_out) begin
      fr_len++;
      fr_crc = crc8_upd(fr_crc, d);
      exp_q.push_back({1'b0, d});
      if (l || fr_len == MAX_LEN) begin
        exp_q.push_back({1'b1, fr_crc});
        fr_len = 0;
        fr_crc = 8'h00;
      end
    end
  endtask

  task automatic wait_q_empty(input bit need_idle);
    int n = 0;
    while (exp_q.size() != 0 || (need_idle && busy)) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        tests++; fails++;
        $display("FAIL drain_timeout: got %0d pending busy=%0b want 0 pending", exp_q.size(), busy);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    // inline-style comparison wrapper for scalar counters only
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    #12;
    tests++;
    if ({in_ready, out_valid, out_last, crc_enable, crc_clr, err_len, err_timeout, busy} !== 8'h00 ||
        out_data !== 8'h00 || crc_byte !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: got ctl=%b out_data=%02h crc_byte=%02h want all zero",
               {in_ready, out_valid, out_last, crc_enable, crc_clr, err_len, err_timeout, busy},
               out_data, crc_byte);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%0b in_ready=%0b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_single_byte();
    clr_cnt = 0; en_cnt = 0;
    send_byte(8'h00, 1'b1, 1'b1);
    wait_q_empty(1'b1);
    chk("single_clr", clr_cnt, 1);
    chk("single_enable", en_cnt, 1);
  endtask

  task automatic test_three_bytes();
    clr_cnt = 0; en_cnt = 0;
    send_byte(8'h31, 1'b0, 1'b1);
    send_byte(8'h32, 1'b0, 1'b1);
    send_byte(8'h33, 1'b1, 1'b1);
    wait_q_empty(1'b1);
    chk("three_clr", clr_cnt, 1);
    chk("three_enable", en_cnt, 3);
  endtask

  task automatic test_stall();
    int n = 0;
    out_ready = 1'b0;
    send_byte(8'hA5, 1'b0, 1'b1);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    in_data = 8'h5A; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold: got v=%0b d=%02h l=%0b rdy=%0b want 1 a5 0 0",
                 out_valid, out_data, out_last, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send_byte(8'h5A, 1'b1, 1'b1);
    wait_q_empty(1'b1);
  endtask

  task automatic test_max_len();
    errlen_cnt = 0; clr_cnt = 0;
    for (int i = 1; i <= 6; i++) send_byte(8'(8'h40 + i), 1'b0, 1'b1);
    send_byte(8'h47, 1'b1, 1'b1);
    wait_q_empty(1'b1);
    chk("maxlen_err_len", errlen_cnt, 1);
    chk("maxlen_clr", clr_cnt, 2);
  endtask

  task automatic test_timeout();
    errtmo_cnt = 0;
    send_byte(8'h11, 1'b0, 1'b1);
    wait_q_empty(1'b0);
    eng_no_done = 1'b1;
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b1, 1'b0);
    fr_len = 0; fr_crc = 8'h00;
    wait_q_empty(1'b1);
    eng_no_done = 1'b0;
    chk("timeout_pulses", errtmo_cnt, 1);
    tests++;
    if (tmo_cyc - en_cyc < TMO || tmo_cyc - en_cyc > TMO + 2) begin
      fails++;
      $display("FAIL timeout_delay: got %0d cycles want %0d..%0d", tmo_cyc - en_cyc, TMO, TMO + 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hAA, 1'b0, 1'b1);
    wait_q_empty(1'b0);
    send_byte(8'hBB, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, out_last, crc_enable, crc_clr, err_len, err_timeout, busy} !== 8'h00 ||
        out_data !== 8'h00 || crc_byte !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: got ctl=%b out_data=%02h crc_byte=%02h want all zero",
               {in_ready, out_valid, out_last, crc_enable, crc_clr, err_len, err_timeout, busy},
               out_data, crc_byte);
    end
    exp_q.delete();
    fr_len = 0; fr_crc = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr_cnt = 0; en_cnt = 0;
    send_byte(8'h5C, 1'b1, 1'b1);
    wait_q_empty(1'b1);
    chk("post_reset_clr", clr_cnt, 1);
    chk("post_reset_enable", en_cnt, 1);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_three_bytes();
    test_stall();
    test_max_len();
    test_timeout();
    test_reset_mid_frame();
    chk("leftover_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
